// File: rtl/dm_pkg.sv
// Shared types and constants for the DM load/store unit: access sizes,
// FSM states and the request-legality check used at accept time.
package dm_pkg;

  localparam int WADDR_WIDTH = 16;
  localparam int DATA_WIDTH  = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_e;

  // Size 3 is reserved; halves and words must be naturally aligned.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
    is_illegal = (size == 2'd3) ||
                 ((size == SZ_H) && off[0]) ||
                 ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Core-side request/response channel plus the DM word-memory port.
// master: the load/store unit; slave: the core and memory around it.
interface dm_lsu_if
  import dm_pkg::*;
#(
  parameter int BADDR_WIDTH = 18,
  parameter int WADDR_WIDTH = 16,
  parameter int DATA_WIDTH  = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [1:0]             req_size;
  logic                   req_unsigned;
  logic [BADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   resp_valid;
  logic [DATA_WIDTH-1:0]  resp_rdata;
  logic                   resp_err;
  logic                   dm_enable;
  logic                   dm_write;
  logic [WADDR_WIDTH-1:0] dm_address;
  logic [DATA_WIDTH-1:0]  dm_in;
  logic [DATA_WIDTH-1:0]  dm_out;
  logic                   dm_stall;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dm_enable, dm_write, dm_address, dm_in,
    input  dm_out, dm_stall
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  dm_enable, dm_write, dm_address, dm_in,
    output dm_out, dm_stall
  );
endinterface

// File: rtl/dm_lane_align.sv
// Byte/half lane handling: extract and extend a lane for loads, and
// splice store data into a fetched word for read-modify-write.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [15:0]           wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = word[{offset[1], 4'b0000} +: 16];
    load_data = word;
    merged    = word;
    case (size)
      SZ_B: begin
        load_data = {{(DATA_WIDTH-8){~is_unsigned & byte_lane[7]}}, byte_lane};
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{(DATA_WIDTH-16){~is_unsigned & half_lane[15]}}, half_lane};
        merged[{offset[1], 4'b0000} +: 16] = wdata;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dm_lsu.sv
// Load/store unit between the core MEM stage and the word-only DM port;
// sub-word stores are performed as read-modify-write.
module dm_lsu
  import dm_pkg::*;
#(
  parameter int BADDR_WIDTH = 18,
  parameter int WADDR_WIDTH = 16,
  parameter int DATA_WIDTH  = 32
) (
  input logic      clk,
  input logic      rst,
  dm_lsu_if.master bus
);
  state_e                 state_q, state_n;
  logic [1:0]             size_q, size_n;
  logic                   uns_q, uns_n;
  logic [1:0]             off_q, off_n;
  logic [15:0]            wdata_q, wdata_n;
  logic                   en_q, en_n, wr_q, wr_n;
  logic [WADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0]  din_q, din_n;
  logic                   rv_q, rv_n, rerr_q, rerr_n;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_n;
  logic [DATA_WIDTH-1:0]  load_data, merged;
  logic                   done;

  dm_lane_align u_align (
    .word        (bus.dm_out),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  // An access finishes on the first enabled cycle without stall.
  assign done = en_q & ~bus.dm_stall;

  always_comb begin
    state_n = state_q;
    size_n  = size_q;
    uns_n   = uns_q;
    off_n   = off_q;
    wdata_n = wdata_q;
    en_n    = en_q;
    wr_n    = wr_q;
    addr_n  = addr_q;
    din_n   = din_q;
    rv_n    = 1'b0;
    rerr_n  = 1'b0;
    rdata_n = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          size_n  = bus.req_size;
          uns_n   = bus.req_unsigned;
          off_n   = bus.req_addr[1:0];
          wdata_n = bus.req_wdata[15:0];
          if (is_illegal(bus.req_size, bus.req_addr[1:0])) begin
            state_n = RESP;
            rv_n    = 1'b1;
            rerr_n  = 1'b1;
          end else begin
            en_n   = 1'b1;
            addr_n = bus.req_addr[BADDR_WIDTH-1:2];
            if (!bus.req_write) begin
              state_n = RD;
            end else if (bus.req_size == SZ_W) begin
              state_n = WR;
              wr_n    = 1'b1;
              din_n   = bus.req_wdata;
            end else begin
              state_n = RMW_RD;
            end
          end
        end
      end
      RD: begin
        if (done) begin
          state_n = RESP;
          en_n    = 1'b0;
          rv_n    = 1'b1;
          rdata_n = load_data;
        end
      end
      WR: begin
        if (done) begin
          state_n = RESP;
          en_n    = 1'b0;
          wr_n    = 1'b0;
          rv_n    = 1'b1;
        end
      end
      RMW_RD: begin
        // Enable drops for one cycle so DM sees a fresh handshake for the write.
        if (done) begin
          state_n = RMW_WR;
          en_n    = 1'b0;
          din_n   = merged;
        end
      end
      RMW_WR: begin
        if (!en_q) begin
          en_n = 1'b1;
          wr_n = 1'b1;
        end else if (!bus.dm_stall) begin
          state_n = RESP;
          en_n    = 1'b0;
          wr_n    = 1'b0;
          rv_n    = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rv_q    <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_n;
      size_q  <= size_n;
      uns_q   <= uns_n;
      off_q   <= off_n;
      wdata_q <= wdata_n;
      en_q    <= en_n;
      wr_q    <= wr_n;
      addr_q  <= addr_n;
      din_q   <= din_n;
      rv_q    <= rv_n;
      rerr_q  <= rerr_n;
      rdata_q <= rdata_n;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = rv_q;
  assign bus.resp_err   = rerr_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.dm_enable  = en_q;
  assign bus.dm_write   = wr_q;
  assign bus.dm_address = addr_q;
  assign bus.dm_in      = din_q;
endmodule
